// File: rtl/fifo_reuse_reader_pkg.sv
// Shared widths, FSM encoding and the tagged word carried from FIFORAM to the PE stream.
package fifo_reuse_reader_pkg;

    localparam int unsigned DW      = 16;
    localparam int unsigned MAXLEN  = 64;
    localparam int unsigned MAXPASS = 16;
    localparam int unsigned LW      = $clog2(MAXLEN + 1);
    localparam int unsigned PW      = $clog2(MAXPASS + 1);

    typedef enum logic [2:0] {IDLE, WAIT, READ, DRAIN, POP} rd_state_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          plast;
        logic          glast;
    } tword_t;

endpackage

// File: rtl/fifo_reuse_reader_if.sv
// Descriptor, FIFORAM and output-stream signals of the reuse reader; master is the reader side.
interface fifo_reuse_reader_if;
    import fifo_reuse_reader_pkg::*;

    logic          i_cfg_rdy;
    logic          o_cfg_ack;
    logic [LW-1:0] i_cfg_len;
    logic [PW-1:0] i_cfg_npass;
    logic [LW-1:0] i_fifo_cnt;
    logic          o_read;
    logic          o_lastpix;
    logic          o_pop;
    logic [DW-1:0] i_rdata;
    logic          i_rvalid;
    logic          o_dout_rdy;
    logic          i_dout_ack;
    logic [DW-1:0] o_dout;
    logic          o_dout_plast;
    logic          o_dout_glast;

    modport master (
        input  i_cfg_rdy, i_cfg_len, i_cfg_npass, i_fifo_cnt, i_rdata, i_rvalid, i_dout_ack,
        output o_cfg_ack, o_read, o_lastpix, o_pop, o_dout_rdy, o_dout, o_dout_plast, o_dout_glast
    );

    modport slave (
        output i_cfg_rdy, i_cfg_len, i_cfg_npass, i_fifo_cnt, i_rdata, i_rvalid, i_dout_ack,
        input  o_cfg_ack, o_read, o_lastpix, o_pop, o_dout_rdy, o_dout, o_dout_plast, o_dout_glast
    );

endinterface

// File: rtl/fifo_reuse_reader_skid.sv
// Two-entry rdy/ack buffer for tagged words; head register drives the output directly.
module fifo_reuse_reader_skid
    import fifo_reuse_reader_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_wr_en,
    input  tword_t     i_wr_word,
    output logic       o_rdy,
    input  logic       i_ack,
    output tword_t     o_word,
    output logic [1:0] o_occ
);

    tword_t r_head;
    tword_t r_tail;
    logic   r_head_v;
    logic   r_tail_v;
    logic   w_pop;

    assign w_pop  = r_head_v & i_ack;
    assign o_rdy  = r_head_v;
    assign o_word = r_head;
    assign o_occ  = 2'(r_head_v) + 2'(r_tail_v);

    // Writer never exceeds two entries, counting a same-cycle pop as freed space.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_head   <= '0;
            r_tail   <= '0;
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_v) begin
                r_head   <= r_tail;
                r_tail_v <= i_wr_en;
                if (i_wr_en) begin
                    r_tail <= i_wr_word;
                end
            end else begin
                r_head_v <= i_wr_en;
                if (i_wr_en) begin
                    r_head <= i_wr_word;
                end
            end
        end else if (i_wr_en) begin
            if (!r_head_v) begin
                r_head   <= i_wr_word;
                r_head_v <= 1'b1;
            end else begin
                r_tail   <= i_wr_word;
                r_tail_v <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_reuse_reader.sv
// Replays one FIFORAM group once per pass, tagging each word with pass/group last flags.
module fifo_reuse_reader
    import fifo_reuse_reader_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    fifo_reuse_reader_if.master io_bus
);

    rd_state_t     r_state;
    rd_state_t     w_next;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_idx;
    logic [PW-1:0] r_npass;
    logic [PW-1:0] r_pass;
    logic          r_inflight;
    logic          r_tag_plast;
    logic          r_tag_glast;

    logic          w_cfg_xfer;
    logic          w_issue;
    logic          w_pop;
    logic          w_plast;
    logic          w_glast;
    logic          w_cnt_ok;
    logic          w_credit_ok;
    logic          w_drained;
    logic          w_dout_xfer;
    logic [2:0]    w_load;
    logic [1:0]    w_occ;
    logic          w_rd_rdy;
    tword_t        w_wr_word;
    tword_t        w_rd_word;

    assign w_plast     = (r_idx == r_len - LW'(1));
    assign w_glast     = w_plast && (r_pass == r_npass - PW'(1));
    assign w_cnt_ok    = (io_bus.i_fifo_cnt >= r_len);
    assign w_dout_xfer = w_rd_rdy & io_bus.i_dout_ack;

    // Slots already committed after this cycle's consumer transfer; two slots in total.
    assign w_load      = 3'(r_inflight) + 3'(w_occ) - 3'(w_dout_xfer);
    assign w_credit_ok = (w_load < 3'd2);
    assign w_drained   = (w_load == 3'd0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cfg_xfer) w_next = WAIT;
            WAIT:    if (w_issue) w_next = w_glast ? DRAIN : READ;
            READ:    if (w_issue && w_glast) w_next = DRAIN;
            DRAIN:   if (w_drained) w_next = POP;
            POP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // WAIT issues the first read itself so a ready FIFORAM costs no extra cycle.
    always_comb begin
        w_cfg_xfer = 1'b0;
        w_issue    = 1'b0;
        w_pop      = 1'b0;
        case (r_state)
            IDLE:    w_cfg_xfer = io_bus.i_cfg_rdy;
            WAIT:    w_issue    = w_cnt_ok && w_credit_ok;
            READ:    w_issue    = w_credit_ok;
            POP:     w_pop      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_len       <= '0;
            r_npass     <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_inflight  <= 1'b0;
            r_tag_plast <= 1'b0;
            r_tag_glast <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_plast <= w_plast;
                r_tag_glast <= w_glast;
            end
            if (w_cfg_xfer) begin
                r_len   <= io_bus.i_cfg_len;
                r_npass <= io_bus.i_cfg_npass;
                r_idx   <= '0;
                r_pass  <= '0;
            end else if (w_issue) begin
                if (w_plast) begin
                    r_idx <= '0;
                    if (!w_glast) begin
                        r_pass <= r_pass + PW'(1);
                    end
                end else begin
                    r_idx <= r_idx + LW'(1);
                end
            end else if (r_state == WAIT) begin
                r_idx  <= '0;
                r_pass <= '0;
            end
        end
    end

    // Responses are only accepted for a read we actually issued.
    assign w_wr_word = '{data: io_bus.i_rdata, plast: r_tag_plast, glast: r_tag_glast};

    fifo_reuse_reader_skid u_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (r_inflight & io_bus.i_rvalid),
        .i_wr_word (w_wr_word),
        .o_rdy     (w_rd_rdy),
        .i_ack     (io_bus.i_dout_ack),
        .o_word    (w_rd_word),
        .o_occ     (w_occ)
    );

    assign io_bus.o_cfg_ack    = w_cfg_xfer;
    assign io_bus.o_read       = w_issue;
    assign io_bus.o_lastpix    = w_issue & w_plast;
    assign io_bus.o_pop        = w_pop;
    assign io_bus.o_dout_rdy   = w_rd_rdy;
    assign io_bus.o_dout       = w_rd_word.data;
    assign io_bus.o_dout_plast = w_rd_word.plast;
    assign io_bus.o_dout_glast = w_rd_word.glast;

endmodule

// File: tb/tb_fifo_reuse_reader.sv
// Directed and randomized groups against a FIFORAM stand-in and an expected-word queue.
module tb_fifo_reuse_reader;
    import fifo_reuse_reader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_reuse_reader_if bus ();

    fifo_reuse_reader dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .io_bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW-1:0] grp_data [MAXLEN];
    logic [DW+1:0] exp_q [$];
    int cur_len = 1, cur_total = 0;
    int rd_in_grp = 0, n_xfer = 0, n_pop = 0, n_lastpix = 0;
    int first_read_cyc = -1, last_read_cyc = -1, first_rdy_cyc = -1, pop_cyc = -1, ack_cyc = -1;
    int ridx = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // FIFORAM stand-in: 1-cycle read latency, index returns to group start on lastpix.
    always @(posedge clk) begin
        if (rst) begin
            bus.i_rvalid <= 1'b0;
            bus.i_rdata  <= '0;
            ridx         <= 0;
        end else begin
            bus.i_rvalid <= bus.o_read;
            if (bus.o_read) begin
                bus.i_rdata <= grp_data[ridx];
                ridx        <= bus.o_lastpix ? 0 : ridx + 1;
            end
        end
    end

    // Output-side checker, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            automatic logic xfer = bus.o_dout_rdy & bus.i_dout_ack;
            chk("outstanding_le2",
                longint'((rd_in_grp + int'(bus.o_read) - n_xfer - int'(xfer)) <= 2), 1);
            if (exp_q.size() == 0) begin
                chk("extra_word", xfer, 0);
            end else if (xfer) begin
                automatic logic [DW+1:0] w = exp_q.pop_front();
                chk("dout_word", {bus.o_dout, bus.o_dout_plast, bus.o_dout_glast}, w);
            end
            if (xfer) n_xfer++;
            if (bus.o_dout_rdy && first_rdy_cyc < 0) first_rdy_cyc = cyc;
            if (bus.o_read) begin
                chk("lastpix", bus.o_lastpix, longint'((rd_in_grp % cur_len) == cur_len - 1));
                chk("read_bound", longint'(rd_in_grp < cur_total), 1);
                if (first_read_cyc < 0) first_read_cyc = cyc;
                last_read_cyc = cyc;
                if (bus.o_lastpix) n_lastpix++;
                rd_in_grp++;
            end else begin
                chk("lastpix_no_read", bus.o_lastpix, 0);
            end
            if (bus.o_pop) begin
                n_pop++;
                pop_cyc = cyc;
            end
            if (bus.o_cfg_ack) ack_cyc = cyc;
        end
    end

    task automatic prep_model(input int len, input int npass);
        for (int i = 0; i < len; i++) grp_data[i] = 16'($urandom);
        exp_q.delete();
        for (int p = 0; p < npass; p++)
            for (int i = 0; i < len; i++)
                exp_q.push_back({grp_data[i], 1'(i == len - 1), 1'((p == npass - 1) && (i == len - 1))});
        cur_len = len; cur_total = len * npass;
        rd_in_grp = 0; n_xfer = 0; n_pop = 0; n_lastpix = 0;
        first_read_cyc = -1; last_read_cyc = -1; first_rdy_cyc = -1; pop_cyc = -1;
    endtask

    task automatic drive_ack(input int mode);
        case (mode)
            0:       bus.i_dout_ack = 1'b1;
            1:       bus.i_dout_ack = ~bus.i_dout_ack;
            default: bus.i_dout_ack = ($urandom_range(0, 3) != 0);
        endcase
    endtask

    task automatic start_group(input int len, input int npass, input int cnt, input bit keep);
        bit found = 0;
        prep_model(len, npass);
        @(posedge clk); #1;
        bus.i_cfg_rdy   = 1'b1;
        bus.i_cfg_len   = LW'(len);
        bus.i_cfg_npass = PW'(npass);
        bus.i_fifo_cnt  = LW'(cnt);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk); #1;
            if (bus.o_cfg_ack) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("cfg_ack_seen", found, 1);
        @(posedge clk); #1;
        if (!keep) bus.i_cfg_rdy = 1'b0;
    endtask

    task automatic finish_group(input int mode, input bit tail);
        for (int k = 0; k < 3000 && n_pop == 0; k++) begin
            @(posedge clk); #1;
            drive_ack(mode);
            @(negedge clk); #1;
        end
        chk("pop_seen", n_pop, 1);
        chk("words_left", exp_q.size(), 0);
        chk("reads_issued", rd_in_grp, cur_total);
        chk("lastpix_count", n_lastpix, cur_total / cur_len);
        if (tail) begin
            repeat (3) begin
                @(posedge clk); #1 bus.i_dout_ack = 1'b1;
                @(negedge clk); #1;
            end
            chk("pop_once", n_pop, 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p, l, np;
        rst = 1'b1;
        bus.i_cfg_rdy = 1'b0; bus.i_cfg_len = '0; bus.i_cfg_npass = '0;
        bus.i_fifo_cnt = '0; bus.i_dout_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_cfg_ack", bus.o_cfg_ack, 0);
        chk("rst_read", bus.o_read, 0);
        chk("rst_lastpix", bus.o_lastpix, 0);
        chk("rst_pop", bus.o_pop, 0);
        chk("rst_dout_rdy", bus.o_dout_rdy, 0);
        chk("rst_dout", bus.o_dout, 0);
        chk("rst_plast", bus.o_dout_plast, 0);
        chk("rst_glast", bus.o_dout_glast, 0);

        // len=4 npass=3, consumer always ready: latencies and drain timing.
        start_group(4, 3, 4, 0);
        finish_group(0, 1);
        chk("ack_to_read", first_read_cyc - ack_cyc, 1);
        chk("read_to_rdy", first_rdy_cyc - first_read_cyc, 2);
        chk("pop_delay", pop_cyc - last_read_cyc, 3);

        // Same group with the consumer toggling.
        start_group(4, 3, 4, 0);
        finish_group(1, 1);

        // Not enough entries: hold in WAIT, then release.
        start_group(4, 2, 2, 0);
        repeat (5) begin
            @(posedge clk); #1;
            @(negedge clk); #1;
            chk("wait_no_read", bus.o_read, 0);
        end
        @(posedge clk); #1 bus.i_fifo_cnt = LW'(4);
        @(negedge clk); #1;
        chk("wait_release_read", bus.o_read, 1);
        finish_group(0, 1);

        // Single entry, single pass.
        start_group(1, 1, 1, 0);
        finish_group(0, 1);
        chk("len1_pop_delay", pop_cyc - last_read_cyc, 3);

        // Reset in the middle of the second pass.
        start_group(8, 4, 8, 0);
        for (int k = 0; k < 200 && rd_in_grp < 12; k++) begin
            @(posedge clk); #1;
            @(negedge clk); #1;
        end
        chk("mid_group_no_pop", n_pop, 0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete(); rd_in_grp = 0; n_xfer = 0;
        @(negedge clk); #1;
        chk("rst2_cfg_ack", bus.o_cfg_ack, 0);
        chk("rst2_read", bus.o_read, 0);
        chk("rst2_lastpix", bus.o_lastpix, 0);
        chk("rst2_pop", bus.o_pop, 0);
        chk("rst2_dout_rdy", bus.o_dout_rdy, 0);
        chk("rst2_dout", bus.o_dout, 0);
        chk("rst2_flags", {bus.o_dout_plast, bus.o_dout_glast}, 0);
        start_group(5, 2, 5, 0);
        finish_group(0, 1);

        // Back-to-back descriptors with cfg_rdy held.
        start_group(3, 2, 3, 1);
        finish_group(0, 0);
        chk("ack_during_pop", bus.o_cfg_ack, 0);
        p = pop_cyc;
        prep_model(3, 2);
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("b2b_ack", bus.o_cfg_ack, 1);
        chk("b2b_ack_cycle", cyc - p, 1);
        @(posedge clk); #1 bus.i_cfg_rdy = 1'b0;
        finish_group(0, 1);

        // Size limits.
        start_group(MAXLEN, 2, MAXLEN, 0);
        finish_group(0, 1);
        start_group(2, MAXPASS, 2, 0);
        finish_group(2, 1);

        // Random groups under random backpressure.
        repeat (4) begin
            l  = $urandom_range(1, 12);
            np = $urandom_range(1, 5);
            start_group(l, np, l + $urandom_range(0, 2), 0);
            finish_group(2, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
